// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types (word, ALU op, arbiter state)
package cpu_types_pkg;

  localparam int WORD_W  = 32;
  localparam int ALUOP_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_EXEC = 1'b1
  } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// rtl/alu_share_arbiter_rr_pick.sv - combinational round-robin picker: first eligible at or after rr_ptr
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int SEL_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  elig,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      automatic int c = int'(rr_ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!found && elig[c]) begin
        found = 1'b1;
        idx   = c[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between NREQ requesters
// with latched operands and a private response register per requester.
module alu_share_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ-1:0][WORD_W-1:0]   req_in1,
  input  logic [NREQ-1:0][WORD_W-1:0]   req_in2,
  input  logic [NREQ-1:0][ALUOP_W-1:0]  req_op,
  output logic [NREQ-1:0]               rsp_valid,
  input  logic [NREQ-1:0]               rsp_ack,
  output logic [NREQ-1:0][WORD_W-1:0]   rsp_out,
  output logic [NREQ-1:0]               rsp_neg,
  output logic [NREQ-1:0]               rsp_over,
  output logic [NREQ-1:0]               rsp_zero,
  output logic [WORD_W-1:0]             alu_in1,
  output logic [WORD_W-1:0]             alu_in2,
  output logic [ALUOP_W-1:0]            aluop,
  input  logic [WORD_W-1:0]             alu_out,
  input  logic                          neg_f,
  input  logic                          over_f,
  input  logic                          zero_f
);

  localparam int SEL_W = $clog2(NREQ);

  arb_state_t                  state_q,     state_d;
  logic [SEL_W-1:0]            rr_ptr_q,    rr_ptr_d;
  logic [SEL_W-1:0]            gnt_idx_q,   gnt_idx_d;
  logic [WORD_W-1:0]           op_in1_q,    op_in1_d;
  logic [WORD_W-1:0]           op_in2_q,    op_in2_d;
  logic [ALUOP_W-1:0]          op_code_q,   op_code_d;
  logic [NREQ-1:0]             rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0][WORD_W-1:0] rsp_out_q,   rsp_out_d;
  logic [NREQ-1:0]             rsp_neg_q,   rsp_neg_d;
  logic [NREQ-1:0]             rsp_over_q,  rsp_over_d;
  logic [NREQ-1:0]             rsp_zero_q,  rsp_zero_d;

  logic [NREQ-1:0]             elig;
  logic                        pick_found;
  logic [SEL_W-1:0]            pick_idx;

  // Registered rsp_valid only: an ack this cycle does not make a requester eligible until next cycle.
  assign elig = req_valid & ~rsp_valid_q;

  rr_pick #(
    .NREQ  (NREQ),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .elig   (elig),
    .rr_ptr (rr_ptr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_idx_d   = gnt_idx_q;
    op_in1_d    = op_in1_q;
    op_in2_d    = op_in2_q;
    op_code_d   = op_code_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ack;
    rsp_out_d   = rsp_out_q;
    rsp_neg_d   = rsp_neg_q;
    rsp_over_d  = rsp_over_q;
    rsp_zero_d  = rsp_zero_q;
    req_ready   = '0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          req_ready[pick_idx] = 1'b1;
          op_in1_d            = req_in1[pick_idx];
          op_in2_d            = req_in2[pick_idx];
          op_code_d           = req_op[pick_idx];
          gnt_idx_d           = pick_idx;
          rr_ptr_d            = (pick_idx == SEL_W'(NREQ - 1)) ? '0 : pick_idx + SEL_W'(1);
          state_d             = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        // The granted slot was empty at accept, so this set never races its own ack.
        rsp_out_d[gnt_idx_q]   = alu_out;
        rsp_neg_d[gnt_idx_q]   = neg_f;
        rsp_over_d[gnt_idx_q]  = over_f;
        rsp_zero_d[gnt_idx_q]  = zero_f;
        rsp_valid_d[gnt_idx_q] = 1'b1;
        state_d                = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      gnt_idx_q   <= '0;
      op_in1_q    <= '0;
      op_in2_q    <= '0;
      op_code_q   <= '0;
      rsp_valid_q <= '0;
      rsp_out_q   <= '0;
      rsp_neg_q   <= '0;
      rsp_over_q  <= '0;
      rsp_zero_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      op_in1_q    <= op_in1_d;
      op_in2_q    <= op_in2_d;
      op_code_q   <= op_code_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_over_q  <= rsp_over_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_over  = rsp_over_q;
  assign rsp_zero  = rsp_zero_q;
  assign alu_in1   = op_in1_q;
  assign alu_in2   = op_in2_q;
  assign aluop     = op_code_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ = 2;

  logic                         CLK = 1'b0;
  logic                         RST = 1'b0;
  logic [NREQ-1:0]              req_valid = '0;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ-1:0][WORD_W-1:0]  req_in1 = '0;
  logic [NREQ-1:0][WORD_W-1:0]  req_in2 = '0;
  logic [NREQ-1:0][ALUOP_W-1:0] req_op = '0;
  logic [NREQ-1:0]              rsp_valid;
  logic [NREQ-1:0]              rsp_ack = '0;
  logic [NREQ-1:0][WORD_W-1:0]  rsp_out;
  logic [NREQ-1:0]              rsp_neg, rsp_over, rsp_zero;
  logic [WORD_W-1:0]            alu_in1, alu_in2, alu_out;
  logic [ALUOP_W-1:0]           aluop;
  logic                         neg_f, over_f, zero_f;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  alu_share_arbiter #(.NREQ(NREQ)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_out(rsp_out),
    .rsp_neg(rsp_neg), .rsp_over(rsp_over), .rsp_zero(rsp_zero),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .aluop(aluop),
    .alu_out(alu_out), .neg_f(neg_f), .over_f(over_f), .zero_f(zero_f)
  );

  // Stand-in ALU for the ops the bench uses.
  always_comb begin
    alu_out = '0;
    over_f  = 1'b0;
    case (aluop)
      ALU_ADD: begin
        alu_out = alu_in1 + alu_in2;
        over_f  = (alu_in1[31] == alu_in2[31]) && (alu_out[31] != alu_in1[31]);
      end
      ALU_SUB: begin
        alu_out = alu_in1 - alu_in2;
        over_f  = (alu_in1[31] != alu_in2[31]) && (alu_out[31] != alu_in1[31]);
      end
      ALU_AND: alu_out = alu_in1 & alu_in2;
      ALU_OR:  alu_out = alu_in1 | alu_in2;
      ALU_XOR: alu_out = alu_in1 ^ alu_in2;
      default: alu_out = '0;
    endcase
    neg_f  = alu_out[31];
    zero_f = (alu_out == '0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset_and_add();
    do_reset();
    tests_run++; if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    tests_run++; if (alu_in1 !== 32'd0) begin tests_failed++; $display("FAIL reset_alu_in1 got=%h exp=0", alu_in1); end
    tests_run++; if (alu_in2 !== 32'd0) begin tests_failed++; $display("FAIL reset_alu_in2 got=%h exp=0", alu_in2); end
    tests_run++; if (aluop !== 4'd0) begin tests_failed++; $display("FAIL reset_aluop got=%h exp=0", aluop); end
    tests_run++; if (rsp_out[0] !== 32'd0) begin tests_failed++; $display("FAIL reset_rsp_out0 got=%h exp=0", rsp_out[0]); end
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_ready got=%b exp=00", req_ready); end

    req_in1[0] = 32'd5; req_in2[0] = 32'd7; req_op[0] = ALU_ADD; req_valid = 2'b01;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL add_ready got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL add_exec_ready got=%b exp=00", req_ready); end
    tests_run++; if (alu_in1 !== 32'd5 || alu_in2 !== 32'd7) begin tests_failed++; $display("FAIL add_operands got=%0d,%0d exp=5,7", alu_in1, alu_in2); end
    tests_run++; if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL add_early_valid got=%b exp=00", rsp_valid); end
    tick();
    tests_run++; if (rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL add_rsp_valid got=%b exp=01", rsp_valid); end
    tests_run++; if (rsp_out[0] !== 32'd12) begin tests_failed++; $display("FAIL add_out got=%0d exp=12", rsp_out[0]); end
    tests_run++; if (rsp_zero[0] !== 1'b0 || rsp_neg[0] !== 1'b0) begin tests_failed++; $display("FAIL add_flags got=z%b n%b exp=z0 n0", rsp_zero[0], rsp_neg[0]); end
    rsp_ack = 2'b01;
    tick();
    rsp_ack = 2'b00;
    #1;
    tests_run++; if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL add_ack_clear got=%b exp=00", rsp_valid); end
    tests_run++; if (rsp_out[0] !== 32'd12) begin tests_failed++; $display("FAIL add_data_held got=%0d exp=12", rsp_out[0]); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_in1[0] = 32'd1;  req_in2[0] = 32'd2;  req_op[0] = ALU_ADD;
    req_in1[1] = 32'd10; req_in2[1] = 32'd20; req_op[1] = ALU_ADD;
    req_valid = 2'b11;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL rr_grant1 got=%b exp=01", req_ready); end
    tick();
    tick();
    tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL rr_grant2 got=%b exp=10", req_ready); end
    tick();
    rsp_ack = 2'b01;
    #1;
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL rr_exec_ready got=%b exp=00", req_ready); end
    tick();
    rsp_ack = 2'b00;
    #1;
    tests_run++; if (rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL rr_capture_ack got=%b exp=10", rsp_valid); end
    tests_run++; if (rsp_out[1] !== 32'd30) begin tests_failed++; $display("FAIL rr_out1 got=%0d exp=30", rsp_out[1]); end
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL rr_grant3 got=%b exp=01", req_ready); end
    tick();
    rsp_ack = 2'b10;
    tick();
    rsp_ack = 2'b00;
    #1;
    tests_run++; if (rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL rr_capture_ack2 got=%b exp=01", rsp_valid); end
    tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL rr_grant4 got=%b exp=10", req_ready); end
    tick();
    tick();
    tests_run++; if (rsp_valid !== 2'b11) begin tests_failed++; $display("FAIL rr_both_valid got=%b exp=11", rsp_valid); end
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL rr_no_grant_unacked got=%b exp=00", req_ready); end
    req_valid = 2'b00;
    rsp_ack = 2'b11;
    tick();
    rsp_ack = 2'b00;
    #1;
    tests_run++; if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL rr_final_clear got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_flags();
    req_in1[1] = 32'h7FFF_FFFF; req_in2[1] = 32'hFFFF_FFFF; req_op[1] = ALU_SUB;
    req_valid = 2'b10;
    #1;
    tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL sub_ready got=%b exp=10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    tests_run++; if (rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL sub_valid got=%b exp=10", rsp_valid); end
    tests_run++; if (rsp_out[1] !== 32'h8000_0000) begin tests_failed++; $display("FAIL sub_out1 got=%h exp=80000000", rsp_out[1]); end
    tests_run++; if (rsp_over[1] !== 1'b1 || rsp_neg[1] !== 1'b1 || rsp_zero[1] !== 1'b0) begin tests_failed++; $display("FAIL sub_flags1 got=o%b n%b z%b exp=o1 n1 z0", rsp_over[1], rsp_neg[1], rsp_zero[1]); end
    rsp_ack = 2'b10;
    req_in1[0] = 32'd3; req_in2[0] = 32'd3; req_op[0] = ALU_SUB;
    req_valid = 2'b01;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL sub0_ready got=%b exp=01", req_ready); end
    tick();
    rsp_ack = 2'b00;
    req_valid = 2'b00;
    tick();
    tests_run++; if (rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL sub0_valid got=%b exp=01", rsp_valid); end
    tests_run++; if (rsp_out[0] !== 32'd0) begin tests_failed++; $display("FAIL sub0_out got=%h exp=0", rsp_out[0]); end
    tests_run++; if (rsp_zero[0] !== 1'b1 || rsp_over[0] !== 1'b0 || rsp_neg[0] !== 1'b0) begin tests_failed++; $display("FAIL sub0_flags got=z%b o%b n%b exp=z1 o0 n0", rsp_zero[0], rsp_over[0], rsp_neg[0]); end
    rsp_ack = 2'b01;
    tick();
    rsp_ack = 2'b00;
    #1;
  endtask

  task automatic test_hold_unacked();
    req_in1[0] = 32'd50; req_in2[0] = 32'd0; req_op[0] = ALU_ADD;
    req_valid = 2'b01;
    tick();
    tick();
    tests_run++; if (rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL hold_setup got=%b exp=01", rsp_valid); end
    req_in1[0] = 32'd100; req_in2[0] = 32'd1;
    req_in1[1] = 32'd2;   req_in2[1] = 32'd2; req_op[1] = ALU_ADD;
    req_valid = 2'b11;
    #1;
    tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL hold_serve1 got=%b exp=10", req_ready); end
    tick();
    tick();
    tests_run++; if (rsp_valid !== 2'b11 || rsp_out[1] !== 32'd4) begin tests_failed++; $display("FAIL hold_r1 got=%b/%0d exp=11/4", rsp_valid, rsp_out[1]); end
    rsp_ack = 2'b01;
    #1;
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL hold_ack_same_cycle got=%b exp=00", req_ready); end
    tick();
    rsp_ack = 2'b00;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL hold_after_ack got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    tests_run++; if (rsp_valid !== 2'b11 || rsp_out[0] !== 32'd101) begin tests_failed++; $display("FAIL hold_r0 got=%b/%0d exp=11/101", rsp_valid, rsp_out[0]); end
    rsp_ack = 2'b11;
    tick();
    rsp_ack = 2'b00;
    #1;
  endtask

  task automatic test_reset_in_exec();
    req_in1[0] = 32'd9; req_in2[0] = 32'd9; req_op[0] = ALU_ADD;
    req_valid = 2'b01;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL rst_accept got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    tests_run++; if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL rst_dropped got=%b exp=00", rsp_valid); end
    tests_run++; if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || aluop !== 4'd0) begin tests_failed++; $display("FAIL rst_operands got=%h,%h,%h exp=0,0,0", alu_in1, alu_in2, aluop); end
    tests_run++; if (rsp_out[0] !== 32'd0 || rsp_out[1] !== 32'd0) begin tests_failed++; $display("FAIL rst_out got=%h,%h exp=0,0", rsp_out[0], rsp_out[1]); end
    tick();
    tests_run++; if (rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL rst_no_late_capture got=%b exp=00", rsp_valid); end
    req_in1[1] = 32'd4; req_in2[1] = 32'd5; req_op[1] = ALU_ADD;
    req_valid = 2'b10;
    #1;
    tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL rst_next_ready got=%b exp=10", req_ready); end
    tick();
    req_valid = 2'b00;
    tick();
    tests_run++; if (rsp_valid !== 2'b10 || rsp_out[1] !== 32'd9) begin tests_failed++; $display("FAIL rst_next_done got=%b/%0d exp=10/9", rsp_valid, rsp_out[1]); end
  endtask

  task automatic test_ack_idle_with_capture();
    rsp_ack = 2'b10;
    tick();
    rsp_ack = 2'b00;
    req_in1[1] = 32'd1; req_in2[1] = 32'd1; req_op[1] = ALU_ADD;
    req_valid = 2'b10;
    #1;
    tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL idleack_ready got=%b exp=10", req_ready); end
    tick();
    req_valid = 2'b00;
    rsp_ack = 2'b01;
    tick();
    rsp_ack = 2'b00;
    #1;
    tests_run++; if (rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL idleack_valid got=%b exp=10", rsp_valid); end
    tests_run++; if (rsp_out[1] !== 32'd2) begin tests_failed++; $display("FAIL idleack_out got=%0d exp=2", rsp_out[1]); end
    tick();
    tests_run++; if (rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL idleack_hold got=%b exp=10", rsp_valid); end
  endtask

  initial begin
    test_reset_and_add();
    test_round_robin();
    test_flags();
    test_hold_unacked();
    test_reset_in_exec();
    test_ack_idle_with_capture();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
